// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and the pipeline-control FSM state type.
package y86_pkg;

    // Instruction codes seen in the pipeline registers
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // Processor status codes
    localparam logic [3:0] S_AOK = 4'h1;
    localparam logic [3:0] S_HLT = 4'h2;
    localparam logic [3:0] S_ADR = 4'h3;
    localparam logic [3:0] S_INS = 4'h4;

    // "No register" selector
    localparam logic [3:0] R_NONE = 4'hF;

    // Run / drain / halted control state
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } pipe_state_e;

    // True for any status other than normal operation
    function automatic logic is_fault(input logic [3:0] stat);
        return stat != S_AOK;
    endfunction

endpackage

// File: rtl/pipe_hazard_detect.sv
// Combinational hazard and exception detection for the 5-stage Y86-64 pipe.
module pipe_hazard_detect
    import y86_pkg::*;
(
    input  logic [3:0] D_icode,
    input  logic [3:0] d_srcA,
    input  logic [3:0] d_srcB,
    input  logic [3:0] E_icode,
    input  logic [3:0] E_dstM,
    input  logic       e_Cnd,
    input  logic [3:0] M_icode,
    input  logic [3:0] m_stat,
    input  logic [3:0] W_stat,
    output logic       load_use,
    output logic       mispred,
    output logic       ret_pend,
    output logic       exc_m,
    output logic       exc_w
);

    // A load in E feeding a source read in D must wait one cycle.
    // Jumps are predicted taken, so a false condition in E is a mispredict.
    // A ret anywhere in D/E/M blocks fetch until its target is known.
    always_comb begin
        load_use = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
                   (E_dstM != R_NONE) &&
                   ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        mispred  = (E_icode == I_JXX) && !e_Cnd;
        ret_pend = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
        exc_m    = is_fault(m_stat);
        exc_w    = is_fault(W_stat);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control unit: stall/bubble generation, CC-write gating and the
// sticky run/drain/halt FSM for the 5-stage Y86-64 core.
// Build option: define PIPE_PERF_CNT_EN to build the saturating performance
// counters; otherwise the counter ports read as zero and no flops exist.
module pipe_hazard_ctrl
    import y86_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [3:0]       M_icode,
    input  logic [3:0]       m_stat,
    input  logic [3:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             set_cc_en,
    output logic             halted,
    output logic [3:0]       proc_stat,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] mp_cnt,
    output logic [CNT_W-1:0] ret_cnt
);

    logic        load_use;
    logic        mispred;
    logic        ret_pend;
    logic        exc_m;
    logic        exc_w;
    pipe_state_e state;

    pipe_hazard_detect u_detect (
        .D_icode  (D_icode),
        .d_srcA   (d_srcA),
        .d_srcB   (d_srcB),
        .E_icode  (E_icode),
        .E_dstM   (E_dstM),
        .e_Cnd    (e_Cnd),
        .M_icode  (M_icode),
        .m_stat   (m_stat),
        .W_stat   (W_stat),
        .load_use (load_use),
        .mispred  (mispred),
        .ret_pend (ret_pend),
        .exc_m    (exc_m),
        .exc_w    (exc_w)
    );

    // Sticky FSM: a memory-stage fault starts draining, a retiring fault
    // (or halt) freezes the pipe and latches its status until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            halted    <= 1'b0;
            proc_stat <= S_AOK;
        end else begin
            case (state)
                ST_RUN: begin
                    if (exc_w) begin
                        state     <= ST_HALTED;
                        halted    <= 1'b1;
                        proc_stat <= W_stat;
                    end else if (exc_m) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (exc_w) begin
                        state     <= ST_HALTED;
                        halted    <= 1'b1;
                        proc_stat <= W_stat;
                    end
                end
                ST_HALTED: begin
                    state <= ST_HALTED;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    // Output mux: hazard equations in RUN/DRAIN, frozen pipe in HALTED,
    // and a flushed-but-not-stalled pipe while reset is asserted.
    always_comb begin
        F_stall   = load_use | ret_pend;
        D_stall   = load_use;
        D_bubble  = mispred | (ret_pend & ~load_use);
        E_bubble  = mispred | load_use;
        M_bubble  = exc_m | exc_w;
        W_stall   = exc_w;
        set_cc_en = (E_icode == I_OPQ) & ~exc_m & ~exc_w;
        if (state == ST_HALTED) begin
            F_stall   = 1'b1;
            D_stall   = 1'b1;
            D_bubble  = 1'b0;
            E_bubble  = 1'b0;
            M_bubble  = 1'b1;
            W_stall   = 1'b1;
            set_cc_en = 1'b0;
        end
        if (!rst_n) begin
            F_stall   = 1'b0;
            D_stall   = 1'b0;
            D_bubble  = 1'b1;
            E_bubble  = 1'b1;
            M_bubble  = 1'b1;
            W_stall   = 1'b0;
            set_cc_en = 1'b0;
        end
    end

    // A load-use stall and a mispredict in the same cycle means the pipe
    // registers upstream are already corrupt; D_stall wins if it happens.
    a_no_lu_with_mispred: assert property (
        @(posedge clk) disable iff (!rst_n)
        (state != ST_HALTED) |-> !(load_use && mispred)
    );

`ifdef PIPE_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cyc_q;
    logic [CNT_W-1:0] lu_q;
    logic [CNT_W-1:0] mp_q;
    logic [CNT_W-1:0] ret_q;

    // Saturating event counters, frozen once the pipe has halted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q <= '0;
            lu_q  <= '0;
            mp_q  <= '0;
            ret_q <= '0;
        end else if (state != ST_HALTED) begin
            if (cyc_q != '1) cyc_q <= cyc_q + CNT_ONE;
            if (load_use && (lu_q != '1)) lu_q <= lu_q + CNT_ONE;
            if (mispred && (mp_q != '1)) mp_q <= mp_q + CNT_ONE;
            if (ret_pend && !load_use && (ret_q != '1)) ret_q <= ret_q + CNT_ONE;
        end
    end

    assign cyc_cnt = cyc_q;
    assign lu_cnt  = lu_q;
    assign mp_cnt  = mp_q;
    assign ret_cnt = ret_q;
`else
    assign cyc_cnt = '0;
    assign lu_cnt  = '0;
    assign mp_cnt  = '0;
    assign ret_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (scoreboard of expected output
// vectors plus a small saturating counter model).
module tb_pipe_hazard_ctrl;
    import y86_pkg::*;

    localparam int TB_CNT_W = 4;
`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] d_icode;
        logic [3:0] srca;
        logic [3:0] srcb;
        logic [3:0] e_icode;
        logic [3:0] e_dstm;
        logic       cnd;
        logic [3:0] m_icode;
        logic [3:0] m_stat;
        logic [3:0] w_stat;
    } stim_t;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, m_stat, W_stat;
    logic       e_Cnd;
    logic       F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc_en, halted;
    logic [3:0] proc_stat;
    logic [TB_CNT_W-1:0] cyc_cnt, lu_cnt, mp_cnt, ret_cnt;

    pipe_hazard_ctrl #(.CNT_W(TB_CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .D_icode   (D_icode),
        .d_srcA    (d_srcA),
        .d_srcB    (d_srcB),
        .E_icode   (E_icode),
        .E_dstM    (E_dstM),
        .e_Cnd     (e_Cnd),
        .M_icode   (M_icode),
        .m_stat    (m_stat),
        .W_stat    (W_stat),
        .F_stall   (F_stall),
        .D_stall   (D_stall),
        .D_bubble  (D_bubble),
        .E_bubble  (E_bubble),
        .M_bubble  (M_bubble),
        .W_stall   (W_stall),
        .set_cc_en (set_cc_en),
        .halted    (halted),
        .proc_stat (proc_stat),
        .cyc_cnt   (cyc_cnt),
        .lu_cnt    (lu_cnt),
        .mp_cnt    (mp_cnt),
        .ret_cnt   (ret_cnt)
    );

    // scoreboard state
    logic [11:0] exp_q[$];
    int n_vec = 0;
    int n_bad = 0;

    // counter model: contribution of the current cycle is applied at the next edge
    logic [TB_CNT_W-1:0] m_cyc = '0, m_lu = '0, m_mp = '0, m_rt = '0;
    bit pend_run = 0, pend_lu = 0, pend_mp = 0, pend_rt = 0;

    // {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc_en, halted, proc_stat}
    function automatic logic [11:0] ev(bit f, bit ds, bit db, bit eb, bit mb, bit ws, bit cc,
                                       bit h, logic [3:0] ps);
        return {f, ds, db, eb, mb, ws, cc, h, ps};
    endfunction

    function automatic logic [11:0] obs();
        return {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc_en, halted, proc_stat};
    endfunction

    function automatic logic [TB_CNT_W-1:0] view(logic [TB_CNT_W-1:0] v);
        return PERF ? v : '0;
    endfunction

    function automatic logic [TB_CNT_W-1:0] sat1(logic [TB_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    function automatic stim_t idle_s();
        stim_t s;
        s.d_icode = I_NOP;  s.srca = 4'h0;  s.srcb = 4'h0;
        s.e_icode = I_NOP;  s.e_dstm = R_NONE; s.cnd = 1'b0;
        s.m_icode = I_NOP;  s.m_stat = S_AOK;  s.w_stat = S_AOK;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        D_icode = s.d_icode; d_srcA = s.srca; d_srcB = s.srcb;
        E_icode = s.e_icode; E_dstM = s.e_dstm; e_Cnd = s.cnd;
        M_icode = s.m_icode; m_stat = s.m_stat; W_stat = s.w_stat;
    endtask

    // driver: one cycle of stimulus, expected outputs pushed to the scoreboard
    task automatic drive(input stim_t s, input logic [11:0] e, input bit lu, input bit mp,
                         input bit rt, input bit run);
        @(posedge clk);
        if (rst_n && pend_run) begin
            m_cyc = sat1(m_cyc);
            if (pend_lu) m_lu = sat1(m_lu);
            if (pend_mp) m_mp = sat1(m_mp);
            if (pend_rt) m_rt = sat1(m_rt);
        end
        #1;
        apply(s);
        exp_q.push_back(e);
        pend_run = run; pend_lu = lu; pend_mp = mp; pend_rt = rt;
    endtask

    task automatic model_reset();
        m_cyc = '0; m_lu = '0; m_mp = '0; m_rt = '0;
        pend_run = 0; pend_lu = 0; pend_mp = 0; pend_rt = 0;
    endtask

    localparam logic [11:0] EV_IDLE = 12'b0000000_0_0001;
    localparam logic [11:0] EV_RST  = 12'b0011100_0_0001;

    task automatic test_reset();
        logic [11:0] got, e;
        apply(idle_s());
        rst_n = 1'b0;
        model_reset();
        #12;
        exp_q.push_back(EV_RST);
        got = obs(); e = exp_q.pop_front(); n_vec++;
        if (got !== e) begin n_bad++; $display("FAIL reset_outputs got=%b exp=%b", got, e); end
        n_vec++;
        if ({cyc_cnt, lu_cnt, mp_cnt, ret_cnt} !== '0) begin
            n_bad++; $display("FAIL reset_counters got=%h exp=0", {cyc_cnt, lu_cnt, mp_cnt, ret_cnt});
        end
        @(negedge clk);
        rst_n = 1'b1;
        pend_run = 1;
    endtask

    task automatic test_idle_cc();
        stim_t s;
        logic [11:0] got, e;
        for (int i = 0; i < 3; i++) begin
            s = idle_s();
            if (i == 1) s.e_icode = I_OPQ;
            drive(s, (i == 1) ? ev(0,0,0,0,0,0,1,0,S_AOK) : EV_IDLE, 0, 0, 0, 1);
            @(negedge clk);
            got = obs(); e = exp_q.pop_front(); n_vec++;
            if (got !== e) begin n_bad++; $display("FAIL idle_cc step%0d got=%b exp=%b", i, got, e); end
        end
        n_vec++;
        if (cyc_cnt !== view(m_cyc)) begin
            n_bad++; $display("FAIL cyc_count got=%0d exp=%0d", cyc_cnt, view(m_cyc));
        end
    endtask

    task automatic test_load_use();
        stim_t s;
        logic [11:0] got, e;
        bit hz;
        for (int i = 0; i < 6; i++) begin
            s = idle_s();
            s.e_icode = (i < 3) ? I_MRMOVQ : I_POPQ;
            s.e_dstm  = (i == 5) ? R_NONE : 4'h3;
            if (i == 3) s.srcb = 4'h3; else if (i == 5) s.srca = R_NONE; else s.srca = 4'h3;
            if (i == 4) begin s.srca = 4'h2; s.srcb = 4'h4; end
            hz = (i != 4) && (i != 5);
            drive(s, hz ? ev(1,1,0,1,0,0,0,0,S_AOK) : EV_IDLE, hz, 0, 0, 1);
            @(negedge clk);
            got = obs(); e = exp_q.pop_front(); n_vec++;
            if (got !== e) begin n_bad++; $display("FAIL load_use step%0d got=%b exp=%b", i, got, e); end
        end
        n_vec++;
        if (lu_cnt !== view(m_lu)) begin
            n_bad++; $display("FAIL lu_count got=%0d exp=%0d", lu_cnt, view(m_lu));
        end
    endtask

    task automatic test_mispred();
        stim_t s;
        logic [11:0] got, e;
        for (int i = 0; i < 4; i++) begin
            s = idle_s();
            s.e_icode = I_JXX;
            s.cnd = i[0];
            drive(s, s.cnd ? EV_IDLE : ev(0,0,1,1,0,0,0,0,S_AOK), 0, !s.cnd, 0, 1);
            @(negedge clk);
            got = obs(); e = exp_q.pop_front(); n_vec++;
            if (got !== e) begin n_bad++; $display("FAIL mispred step%0d got=%b exp=%b", i, got, e); end
        end
        n_vec++;
        if (mp_cnt !== view(m_mp)) begin
            n_bad++; $display("FAIL mp_count got=%0d exp=%0d", mp_cnt, view(m_mp));
        end
    endtask

    task automatic test_ret();
        stim_t s;
        logic [11:0] got, e;
        for (int i = 0; i < 5; i++) begin
            s = idle_s();
            case (i)
                0: s.d_icode = I_RET;
                1: s.e_icode = I_RET;
                2: s.m_icode = I_RET;
                default: ;
            endcase
            drive(s, (i < 3) ? ev(1,0,1,0,0,0,0,0,S_AOK) : EV_IDLE, 0, 0, i < 3, 1);
            @(negedge clk);
            got = obs(); e = exp_q.pop_front(); n_vec++;
            if (got !== e) begin n_bad++; $display("FAIL ret step%0d got=%b exp=%b", i, got, e); end
        end
        // ret in D behind a load-use: the stall wins, no D bubble
        s = idle_s();
        s.d_icode = I_RET; s.e_icode = I_MRMOVQ; s.e_dstm = 4'h7; s.srca = 4'h7;
        drive(s, ev(1,1,0,1,0,0,0,0,S_AOK), 1, 0, 0, 1);
        @(negedge clk);
        got = obs(); e = exp_q.pop_front(); n_vec++;
        if (got !== e) begin n_bad++; $display("FAIL ret_with_lu got=%b exp=%b", got, e); end
        drive(idle_s(), EV_IDLE, 0, 0, 0, 1);
        @(negedge clk);
        got = obs(); e = exp_q.pop_front(); n_vec++;
        if (got !== e) begin n_bad++; $display("FAIL ret_after got=%b exp=%b", got, e); end
        n_vec++;
        if (ret_cnt !== view(m_rt)) begin
            n_bad++; $display("FAIL ret_count got=%0d exp=%0d", ret_cnt, view(m_rt));
        end
        n_vec++;
        if (lu_cnt !== view(m_lu)) begin
            n_bad++; $display("FAIL lu_count2 got=%0d exp=%0d", lu_cnt, view(m_lu));
        end
    endtask

    task automatic test_exception();
        stim_t s;
        logic [11:0] got, e;
        logic [TB_CNT_W-1:0] frozen;
        for (int i = 0; i < 14; i++) begin
            s = idle_s();
            if (i < 2) s.e_icode = I_OPQ;
            if (i == 0) s.m_stat = S_ADR;
            if (i == 1) s.w_stat = S_ADR;
            if (i >= 2) begin
                case (i % 3)
                    0: begin s.e_icode = I_JXX; s.cnd = 1'b0; end
                    1: s.e_icode = I_OPQ;
                    default: s.d_icode = I_RET;
                endcase
            end
            case (i)
                0: e = ev(0,0,0,0,1,0,0,0,S_AOK);
                1: e = ev(0,0,0,0,1,1,0,0,S_AOK);
                default: e = ev(1,1,0,0,1,1,0,1,S_ADR);
            endcase
            drive(s, e, 0, 0, 0, i < 2);
            @(negedge clk);
            got = obs(); e = exp_q.pop_front(); n_vec++;
            if (got !== e) begin n_bad++; $display("FAIL exception step%0d got=%b exp=%b", i, got, e); end
            if (i == 3) frozen = view(m_cyc);
        end
        n_vec++;
        if (cyc_cnt !== frozen) begin
            n_bad++; $display("FAIL cyc_frozen got=%0d exp=%0d", cyc_cnt, frozen);
        end
    endtask

    task automatic test_async_reset();
        logic [11:0] got, e;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        exp_q.push_back(EV_RST);
        got = obs(); e = exp_q.pop_front(); n_vec++;
        if (got !== e) begin n_bad++; $display("FAIL async_reset got=%b exp=%b", got, e); end
        n_vec++;
        if ({cyc_cnt, lu_cnt, mp_cnt, ret_cnt} !== '0) begin
            n_bad++; $display("FAIL async_counters got=%h exp=0", {cyc_cnt, lu_cnt, mp_cnt, ret_cnt});
        end
        drive(idle_s(), EV_RST, 0, 0, 0, 0);
        @(negedge clk);
        got = obs(); e = exp_q.pop_front(); n_vec++;
        if (got !== e) begin n_bad++; $display("FAIL held_reset got=%b exp=%b", got, e); end
        rst_n = 1'b1;
        pend_run = 1;
        for (int i = 0; i < 2; i++) begin
            drive(idle_s(), EV_IDLE, 0, 0, 0, 1);
            @(negedge clk);
            got = obs(); e = exp_q.pop_front(); n_vec++;
            if (got !== e) begin n_bad++; $display("FAIL after_reset step%0d got=%b exp=%b", i, got, e); end
        end
        n_vec++;
        if (cyc_cnt !== view(m_cyc)) begin
            n_bad++; $display("FAIL cyc_restart got=%0d exp=%0d", cyc_cnt, view(m_cyc));
        end
    endtask

    task automatic test_halt_instr();
        stim_t s;
        logic [11:0] got, e;
        for (int i = 0; i < 4; i++) begin
            s = idle_s();
            if (i == 0) s.w_stat = S_HLT;
            drive(s, (i == 0) ? ev(0,0,0,0,1,1,0,0,S_AOK) : ev(1,1,0,0,1,1,0,1,S_HLT),
                  0, 0, 0, i == 0);
            @(negedge clk);
            got = obs(); e = exp_q.pop_front(); n_vec++;
            if (got !== e) begin n_bad++; $display("FAIL halt_instr step%0d got=%b exp=%b", i, got, e); end
        end
    endtask

    task automatic test_saturation();
        logic [11:0] got, e;
        int n;
        n = $urandom_range(18, 24);
        for (int i = 0; i < n; i++) begin
            drive(idle_s(), EV_IDLE, 0, 0, 0, 1);
            @(negedge clk);
            got = obs(); e = exp_q.pop_front(); n_vec++;
            if (got !== e) begin n_bad++; $display("FAIL sat_idle step%0d got=%b exp=%b", i, got, e); end
        end
        n_vec++;
        if (cyc_cnt !== view(m_cyc)) begin
            n_bad++; $display("FAIL cyc_saturate got=%0d exp=%0d", cyc_cnt, view(m_cyc));
        end
    endtask

    initial begin
        test_reset();
        test_idle_cc();
        test_load_use();
        test_mispred();
        test_ret();
        test_exception();
        test_async_reset();
        test_halt_instr();
        test_async_reset();
        test_saturation();
        if (exp_q.size() != 0) begin
            n_bad++; $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline control unit for the 5-stage Y86-64 core. It generates the stall and bubble signals for the F/D/E/M/W pipeline registers, which resolves load-use hazards, mispredicted jumps and ret, and it gates condition-code updates. It holds a sticky run/drain/halt FSM that freezes the pipe once an exception or halt retires. Optional performance counters are included.

Parameters:
CNT_W, 32, width of each performance counter (saturating)

Ports:
clk  in  1  core clock; all state updates on posedge
rst_n  in  1  reset, asynchronous, active-low
D_icode  in  4  icode held in D register
d_srcA  in  4  decode-stage srcA
d_srcB  in  4  decode-stage srcB
E_icode  in  4  icode held in E register
E_dstM  in  4  E-register dstM
e_Cnd  in  1  execute-stage branch condition
M_icode  in  4  icode held in M register
m_stat  in  4  memory-stage status
W_stat  in  4  W-register status
F_stall  out  1  hold F (PC) register
D_stall  out  1  hold D register
D_bubble  out  1  load NOP into D
E_bubble  out  1  load NOP into E
M_bubble  out  1  load NOP into M
W_stall  out  1  hold W register
set_cc_en  out  1  permit CC write this cycle
halted  out  1  FSM in HALTED
proc_stat  out  4  latched final status
cyc_cnt, lu_cnt, mp_cnt, ret_cnt  out  CNT_W each  performance counters

Behaviour:
- Clock and reset: the clock is clk. Reset is rst_n, asynchronous and active-low.
- Encodings (y86_pkg):
  - icodes: HALT 0, NOP 1, OPQ 6, JXX 7, RET 9, MRMOVQ 5, POPQ B
  - stat: AOK 1, HLT 2, ADR 3, INS 4
  - RNONE F
- Hazard terms (combinational):
  - load_use = E_icode∈{MRMOVQ,POPQ} && E_dstM!=RNONE && (E_dstM==d_srcA || E_dstM==d_srcB)
  - mispred = E_icode==JXX && !e_Cnd
  - ret_pend = RET ∈ {D_icode,E_icode,M_icode}
  - exc_m = m_stat!=AOK
  - exc_w = W_stat!=AOK
- Outputs in RUN/DRAIN:
  - F_stall = load_use | ret_pend
  - D_stall = load_use
  - D_bubble = mispred | (ret_pend & !load_use)
  - E_bubble = mispred | load_use
  - M_bubble = exc_m | exc_w
  - W_stall = exc_w
  - set_cc_en = E_icode==OPQ & !exc_m & !exc_w
- Outputs in HALTED: F_stall=D_stall=W_stall=M_bubble=1; D_bubble=E_bubble=set_cc_en=0.
- While rst_n=0: F_stall=D_stall=W_stall=set_cc_en=0; D_bubble=E_bubble=M_bubble=1.
- Precedence: a simultaneous mispred and load_use is impossible by construction, but if both are present, E_bubble=1 and D_bubble=1 with D_stall=1. D_stall wins, and the implementation flags this with an assertion.
- FSM, 2-bit encoding; reset state RUN:
  - RUN→DRAIN when exc_m.
  - RUN→HALTED directly when exc_w; this covers the case where DRAIN is skipped.
  - DRAIN→HALTED when exc_w.
  - DRAIN→RUN is illegal; DRAIN stays until exc_w.
  - HALTED is sticky until rst_n=0.
- Transition timing: the transition is registered at posedge. HALTED outputs take effect the cycle after W_stat!=AOK is first seen; in that first cycle, the RUN/DRAIN equations already give W_stall=1.
- proc_stat:
  - reset value AOK
  - loads W_stat on the RUN/DRAIN→HALTED edge
  - otherwise holds
- halted: registered, reset 0.
- Reset mid-operation: FSM, proc_stat and counters clear immediately (asynchronously).

Optional Feature:
PIPE_PERF_CNT_EN.
- Defined:
  - Counters reset to 0 and count only in RUN/DRAIN.
  - cyc_cnt increments every cycle; lu_cnt on load_use; mp_cnt on mispred; ret_cnt on (ret_pend & !load_use).
  - Each counter saturates at 2^CNT_W−1.
  - Counters freeze in HALTED.
- Undefined: counter ports stay present, tied to 0, and no counter flops are built.

Decomposition:
- y86_pkg: icode constants, stat constants, RNONE, and the FSM state enum {RUN, DRAIN, HALTED}.
- Sub-module pipe_hazard_detect: purely combinational. Produces load_use, mispred, ret_pend, exc_m and exc_w from the stage inputs.
- pipe_hazard_ctrl: instantiates pipe_hazard_detect and owns the FSM, output muxing and counters.

Test Plan:
- Load-use: E_icode=5, E_dstM=3, d_srcA=3, all stat=1 → F_stall=D_stall=E_bubble=1, D_bubble=0. With PIPE_PERF_CNT_EN, lu_cnt increments by 1 per cycle held.
- Mispredict: E_icode=7, e_Cnd=0 → D_bubble=E_bubble=1 and F_stall=0. With e_Cnd=1, all outputs are 0.
- Ret: D_icode=9 for 1 cycle, then E_icode=9, then M_icode=9 → F_stall=D_bubble=1 for exactly 3 cycles, then both 0.
- Exception drain: m_stat=3 for 1 cycle, then W_stat=3 → M_bubble=1 in both cycles; set_cc_en=0 for E_icode=6; W_stall=1 in the W cycle. Next cycle: halted=1, proc_stat=3, and the HALTED output pattern holds for 10+ cycles with all inputs returned to AOK.
- Halt instruction: W_stat=2 from RUN with no prior m_stat fault → HALTED next cycle and proc_stat=2.
- Async reset mid-HALTED: drop rst_n between edges → halted=0 and proc_stat=1 immediately, counters 0, D_bubble=E_bubble=M_bubble=1. After release, the block is in RUN.
